wb_stage_q: RTL
===============

# wb_stage_q

Parametrised write-back stage for the pipelined CPU. It takes retiring instructions from the memory stage over a valid/ready handshake and selects the ALU result or the load data (mem2reg). Load data is aligned and sign/zero-extended by access size. Results are buffered in a DEPTH-entry queue that drains into the register-file write port under `wr_ready` back-pressure. The queue head is exported for forwarding.

## Interface
- XLEN, 32, datapath width; legal values 32 or 64.
- NREGS, 32, register count; RA = clog2(NREGS).
- DEPTH, 2, queue entries; power of two, ≥2.
- OB = clog2(XLEN/8), byte-offset width (derived, not overridable).
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  memory stage presents an instruction.
- in_ready  out  1  stage can accept; equals !full.
- in_regwr  in  1  instruction writes a register.
- in_rw  in  RA  destination register.
- in_mem2reg  in  1  0 = select in_result, 1 = select extracted in_dmem.
- in_size  in  2  00 byte, 01 half, 10 word, 11 double (XLEN=64 only).
- in_unsigned  in  1  zero-extend the load when 1.
- in_addr_lo  in  OB  low address bits of the load.
- in_result  in  XLEN  execute result.
- in_dmem  in  XLEN  raw data-memory word.
- flush  in  1  discard the queue and any same-cycle input.
- wr_ready  in  1  register-file port accepts a write this cycle.
- regwr  out  1  write strobe; high when the queue is non-empty.
- rw  out  RA  head destination.
- busW  out  XLEN  head data.
- misalign_err  out  1  one-cycle pulse on a dropped misaligned load.
- count  out  clog2(DEPTH)+1  current occupancy.

## Operation
- Accept: in_valid && in_ready && !flush.
- Dropped without enqueue (accept still completes):
  - in_regwr=0;
  - in_rw=0 (register 0 is never written);
  - misaligned load.
- Misaligned load: mem2reg=1 with half and addr_lo[0]≠0, word and addr_lo[1:0]≠0, or double and addr_lo≠0. Such a load pulses misalign_err the following cycle.
- Load extraction (mem2reg=1):
  - lane = in_dmem >> (8·addr_lo), little-endian;
  - keep the low 8/16/32/64 bits;
  - sign-extend from the top kept bit, or zero-extend when in_unsigned=1.
  - size 11 with XLEN=32 is treated as word.
  - word with XLEN=32 passes through unchanged.
- mem2reg=0: busW data = in_result unmodified; size, unsigned and addr_lo are ignored.
- Queue: circular FIFO, extraction done before enqueue.
  - Pop on regwr && wr_ready.
  - Push and pop may occur in the same cycle; count is unchanged in that case.
  - Pointers wrap modulo DEPTH.
- Head outputs (regwr, rw, busW) drive the register-file port and the ID-stage bypass directly.
- Flush: at the next edge, count=0 and both pointers reset. A concurrent pop and push are both discarded, and misalign_err is not raised.
- Reset (async, rst_n=0):
  - count=0, pointers=0, regwr=0, misalign_err=0;
  - rw=0 and busW=0 (head outputs are forced to 0 when empty);
  - in_ready=1 immediately.

## Timing
- Latency: an instruction accepted at edge N drives regwr=1 in cycle N+1 if the queue was empty.
- in_ready is combinational from count only. A full queue with a pending pop does not accept in that cycle (no ready-through path).
- With wr_ready held high and in_valid every cycle, throughput is one write per cycle and the queue never exceeds one entry.
- regwr, rw and busW are stable while wr_ready=0.
- misalign_err is registered and high exactly one cycle.
- rst_n deassertion is synchronised by the integrator. The block samples inputs from the first rising edge after release.

## Test plan
- Basic select, XLEN=32, wr_ready=1.
  - rw=1, mem2reg=0, result=3, dmem=7 -> next cycle regwr=1, rw=1, busW=3.
  - rw=2, mem2reg=1, word -> busW=7.
  - regwr=0, rw=3 -> regwr=0.
  - rw=0 with regwr=1 -> no write.
- Extraction, dmem=0x80F0_7F81.
  - byte at offset 0, signed -> 0xFFFF_FF81; unsigned -> 0x81.
  - byte at offset 3, signed -> 0xFFFF_FF80.
  - half at offset 2, signed -> 0xFFFF_80F0.
  - half at offset 1 -> no write; misalign_err pulses one cycle.
- Back-pressure, DEPTH=2, wr_ready=0.
  - Push 3 valid writes -> first two accepted, in_ready=0, count=2, head unchanged.
  - Raise wr_ready -> FIFO order preserved; third accepted once count<2.
- Simultaneous push/pop with count=1 and wr_ready=1 -> count stays 1; the pointer wrap over 8 iterations keeps data order.
- Flush with count=2 and valid input -> next cycle count=0, regwr=0; the input is not stored.
- Async reset mid-drain: rst_n low between edges -> regwr, busW and count go to 0 without a clock edge; in_ready=1.
- XLEN=64: double load at offset 0 -> full 64 bits; word at offset 4 signed with upper word 0x8000_0000 -> 0xFFFF_FFFF_8000_0000.

Source files
------------

// File: rtl/wb_stage_q.sv
// Write-back stage: selects ALU result or aligned/extended load data and queues
// register-file writes in a DEPTH-entry FIFO whose head also feeds the bypass.
module wb_stage_q #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned RA = $clog2(NREGS),
  localparam int unsigned OB = $clog2(XLEN / 8),
  localparam int unsigned CW = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_regwr,
  input  logic [RA-1:0]   in_rw,
  input  logic            in_mem2reg,
  input  logic [1:0]      in_size,
  input  logic            in_unsigned,
  input  logic [OB-1:0]   in_addr_lo,
  input  logic [XLEN-1:0] in_result,
  input  logic [XLEN-1:0] in_dmem,
  input  logic            flush,
  input  logic            wr_ready,
  output logic            regwr,
  output logic [RA-1:0]   rw,
  output logic [XLEN-1:0] busW,
  output logic            misalign_err,
  output logic [CW-1:0]   count
);

  localparam int unsigned PW = CW - 1;

  logic [RA-1:0]   rw_mem   [DEPTH];
  logic [XLEN-1:0] data_mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;

  logic            full;
  logic            accept;
  logic            push;
  logic            pop;
  logic            misaligned;
  logic [1:0]      eff_size;
  logic [XLEN-1:0] lane;
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] wr_data;

  // Doubleword requests on a 32-bit datapath degrade to word accesses.
  always_comb begin
    eff_size = in_size;
    if (XLEN == 32 && in_size == 2'b11) begin
      eff_size = 2'b10;
    end
  end

  // Alignment check against the effective access size.
  always_comb begin
    misaligned = 1'b0;
    if (in_mem2reg) begin
      case (eff_size)
        2'b01:   misaligned = in_addr_lo[0];
        2'b10:   misaligned = |in_addr_lo[1:0];
        2'b11:   misaligned = |in_addr_lo;
        default: misaligned = 1'b0;
      endcase
    end
  end

  // Little-endian lane select, then sign/zero extension from the top kept bit.
  always_comb begin
    lane      = in_dmem >> {in_addr_lo, 3'b000};
    load_data = lane;
    case (eff_size)
      2'b00: load_data = in_unsigned ? XLEN'(lane[7:0])  : XLEN'($signed(lane[7:0]));
      2'b01: load_data = in_unsigned ? XLEN'(lane[15:0]) : XLEN'($signed(lane[15:0]));
      2'b10: load_data = in_unsigned ? XLEN'(lane[31:0]) : XLEN'($signed(lane[31:0]));
      default: load_data = lane;
    endcase
    wr_data = in_mem2reg ? load_data : in_result;
  end

  assign full     = (count == CW'(DEPTH));
  assign in_ready = !full;
  assign accept   = in_valid && !full && !flush;
  assign push     = accept && in_regwr && (in_rw != '0) && !misaligned;
  assign regwr    = (count != '0);
  assign pop      = regwr && wr_ready;

  // Head is masked to zero when empty so the bypass never sees stale data.
  assign rw   = regwr ? rw_mem[rd_ptr]   : '0;
  assign busW = regwr ? data_mem[rd_ptr] : '0;

  // Occupancy, pointers and the misalign pulse; flush discards everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count        <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      misalign_err <= 1'b0;
    end else begin
      misalign_err <= accept && misaligned;
      if (flush) begin
        count  <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + PW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PW'(1);
        end
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  // Payload storage needs no reset: it is only observed while occupied.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      rw_mem[wr_ptr]   <= in_rw;
      data_mem[wr_ptr] <= wr_data;
    end
  end

endmodule
